// File: rtl/mc_ctrl_ext.sv
`default_nettype none
// ============================================================================
// Module  : mc_ctrl_ext
// Purpose : Multicycle MIPS control FSM with I-type ops, BNE, JR, a memory
//           ready handshake with timeout, and an illegal-opcode trap.
// Rev     : 1.0  initial release
// ============================================================================
module mc_ctrl_ext #(
    parameter int MEM_WAIT_EN = 1,
    parameter int TIMEOUT     = 15,
    parameter int TRAP_HALT   = 0,
    parameter int JR_EN       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OP,
    input  logic [5:0] FUNCT,
    input  logic       mem_ready,
    output logic [1:0] RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       ExtOp,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] MemtoReg,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [4:0] state
);

    typedef enum logic [4:0] {
        S_IF     = 5'd0,
        S_ID     = 5'd1,
        S_EX_LS  = 5'd2,
        S_MEM_RD = 5'd3,
        S_WB_LS  = 5'd4,
        S_MEM_ST = 5'd5,
        S_EX_R   = 5'd6,
        S_WB_R   = 5'd7,
        S_BR_CPN = 5'd8,
        S_J_CPN  = 5'd9,
        S_JAL    = 5'd10,
        S_EX_I   = 5'd11,
        S_WB_I   = 5'd12,
        S_JR     = 5'd13,
        S_TRAP   = 5'd14,
        S_RST    = 5'd31
    } state_t;

    typedef struct packed {
        logic [1:0] regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic [1:0] memtoreg;
        logic       pcwrite;
        logic       pcwritecond;
        logic       branchne;
        logic [1:0] pcsource;
        logic       fetch;
    } ctrl_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    localparam int c_CW = (TIMEOUT < 2) ? 2 : $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TLAST = c_CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_CW-1:0] c_ONE   = {{(c_CW-1){1'b0}}, 1'b1};

    state_t          r_state;
    ctrl_t           r_ctl;
    logic [c_CW-1:0] r_cnt;
    logic            r_illegal;
    logic            r_mem_timeout;

    state_t          w_next;
    logic [c_CW-1:0] w_cnt;
    logic            w_ill;
    logic            w_to;
    logic            w_ready;
    logic            w_wait_state;
    logic            w_expire;

    // Control word for a state; registered from the next state so outputs are glitch-free.
    function automatic ctrl_t f_decode(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_IF: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
                c.fetch   = 1'b1;
            end
            S_ID: begin
                c.alusrcb = 2'b11;
            end
            S_EX_LS: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEM_RD: begin
                c.iord    = 1'b1;
                c.memread = 1'b1;
            end
            S_WB_LS: begin
                c.regwrite = 1'b1;
                c.memtoreg = 2'b01;
            end
            S_MEM_ST: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EX_R: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            S_WB_R: begin
                c.regwrite = 1'b1;
                c.regdst   = 2'b01;
            end
            S_BR_CPN: begin
                c.alusrca     = 1'b1;
                c.aluop       = 2'b01;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'b01;
                c.branchne    = (op == c_OP_BNE);
            end
            S_J_CPN: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b10;
            end
            S_JAL: begin
                c.regwrite = 1'b1;
                c.regdst   = 2'b10;
                c.memtoreg = 2'b10;
            end
            S_EX_I: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = 2'b11;
            end
            S_WB_I: begin
                c.regwrite = 1'b1;
            end
            S_JR: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b11;
            end
            default: ;
        endcase
        return c;
    endfunction

    assign w_ready      = mem_ready || (MEM_WAIT_EN == 0);
    assign w_wait_state = (r_state == S_IF) || (r_state == S_MEM_RD) || (r_state == S_MEM_ST);
    // A ready in the final wait cycle beats the timeout.
    assign w_expire     = (TIMEOUT != 0) && (r_cnt == c_TLAST) && !w_ready;

    always_comb begin
        w_next = r_state;
        w_cnt  = '0;
        w_ill  = 1'b0;
        w_to   = 1'b0;
        if (w_wait_state && !w_ready && !w_expire) begin
            w_cnt = r_cnt + c_ONE;
        end
        case (r_state)
            S_RST: w_next = S_IF;
            S_IF: begin
                if (w_ready) begin
                    w_next = S_ID;
                end else if (w_expire) begin
                    w_next = S_TRAP;
                    w_to   = 1'b1;
                end
            end
            S_ID: begin
                case (OP)
                    c_OP_RTYPE: w_next = ((JR_EN != 0) && (FUNCT == c_FN_JR)) ? S_JR : S_EX_R;
                    c_OP_J:     w_next = S_J_CPN;
                    c_OP_JAL:   w_next = S_JAL;
                    c_OP_LW,
                    c_OP_SW:    w_next = S_EX_LS;
                    c_OP_BEQ,
                    c_OP_BNE:   w_next = S_BR_CPN;
                    c_OP_ADDI,
                    c_OP_ANDI,
                    c_OP_ORI,
                    c_OP_SLTI:  w_next = S_EX_I;
                    default: begin
                        w_next = S_TRAP;
                        w_ill  = 1'b1;
                    end
                endcase
            end
            S_EX_LS: w_next = (OP == c_OP_SW) ? S_MEM_ST : S_MEM_RD;
            S_MEM_RD: begin
                if (w_ready) begin
                    w_next = S_WB_LS;
                end else if (w_expire) begin
                    w_next = S_TRAP;
                    w_to   = 1'b1;
                end
            end
            S_MEM_ST: begin
                if (w_ready) begin
                    w_next = S_IF;
                end else if (w_expire) begin
                    w_next = S_TRAP;
                    w_to   = 1'b1;
                end
            end
            S_EX_R:  w_next = S_WB_R;
            S_EX_I:  w_next = S_WB_I;
            S_JAL:   w_next = S_J_CPN;
            S_WB_LS,
            S_WB_R,
            S_WB_I,
            S_BR_CPN,
            S_J_CPN,
            S_JR:    w_next = S_IF;
            S_TRAP: begin
                if (TRAP_HALT != 0) begin
                    w_ill = r_illegal;
                    w_to  = r_mem_timeout;
                end else begin
                    w_next = S_IF;
                end
            end
            default: w_next = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_RST;
            r_ctl         <= '0;
            r_cnt         <= '0;
            r_illegal     <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_ctl         <= f_decode(w_next, OP);
            r_cnt         <= w_cnt;
            r_illegal     <= w_ill;
            r_mem_timeout <= w_to;
        end
    end

    // Fetch strobes only fire in the cycle the memory actually delivers.
    assign IRWrite     = r_ctl.fetch & w_ready;
    assign PCWrite     = r_ctl.pcwrite | (r_ctl.fetch & w_ready);
    assign RegDst      = r_ctl.regdst;
    assign RegWrite    = r_ctl.regwrite;
    assign ALUSrcA     = r_ctl.alusrca;
    assign ALUSrcB     = r_ctl.alusrcb;
    assign ALUOp       = r_ctl.aluop;
    assign IorD        = r_ctl.iord;
    assign MemRead     = r_ctl.memread;
    assign MemWrite    = r_ctl.memwrite;
    assign MemtoReg    = r_ctl.memtoreg;
    assign PCWriteCond = r_ctl.pcwritecond;
    assign BranchNe    = r_ctl.branchne;
    assign PCSource    = r_ctl.pcsource;
    assign ExtOp       = !((OP == c_OP_ANDI) || (OP == c_OP_ORI));
    assign illegal     = r_illegal;
    assign mem_timeout = r_mem_timeout;
    assign state       = r_state;

endmodule
`default_nettype wire
